// File: rtl/decoder_seq.sv
// Sequenced one-hot address decoder. It holds each decoded output for PULSE cycles.
// Define DECODER_SEQ_SCAN_EN to build in the optional scan mode, which walks every index from 0 to LIMIT.
module decoder_seq #(
  parameter int AW    = 6,
  parameter int PULSE = 1,
  parameter int LIMIT = 2**AW-1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        a,
  input  logic                 scan_go,
  output logic [(2**AW)-1:0]   y,
  output logic [AW-1:0]        idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int OW = 2**AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
`ifdef DECODER_SEQ_SCAN_EN
  localparam logic [1:0] S_SCAN = 2'd2;
`endif

  localparam logic [7:0]    HOLD_LAST = 8'(PULSE-1);
  localparam logic [AW-1:0] LIM_IDX   = AW'(LIMIT);
  localparam logic [OW-1:0] ONE       = {{(OW-1){1'b0}}, 1'b1};

  logic [1:0] state;
  logic [7:0] cnt;
  logic       hold_last;
  logic       in_range;
  logic       accept;

  assign hold_last = (cnt == HOLD_LAST);
  assign in_range  = (a <= LIM_IDX);
  assign busy      = (state != S_IDLE);
  assign accept    = in_valid & in_ready;

  // A new request is accepted from IDLE, or in the last cycle of a hold so back-to-back pulses have no gap.
  always_comb begin
    in_ready = 1'b0;
    if (en) begin
`ifdef DECODER_SEQ_SCAN_EN
      if (state == S_IDLE && !scan_go)
        in_ready = 1'b1;
`else
      if (state == S_IDLE)
        in_ready = 1'b1;
`endif
      else if (state == S_HOLD && hold_last)
        in_ready = 1'b1;
    end
  end

`ifndef DECODER_SEQ_SCAN_EN
  logic unused_scan_go;
  assign unused_scan_go = scan_go;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      y     <= '0;
      idx   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (!en) begin
        state <= S_IDLE;
        cnt   <= '0;
        y     <= '0;
        idx   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt <= '0;
`ifdef DECODER_SEQ_SCAN_EN
            if (scan_go) begin
              state <= S_SCAN;
              y     <= ONE;
              idx   <= '0;
            end else
`endif
            if (accept) begin
              if (in_range) begin
                state <= S_HOLD;
                y     <= ONE << a;
                idx   <= a;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (hold_last) begin
              done <= 1'b1;
              cnt  <= '0;
              if (accept && in_range) begin
                y   <= ONE << a;
                idx <= a;
              end else begin
                state <= S_IDLE;
                y     <= '0;
                idx   <= '0;
                err   <= accept;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
`ifdef DECODER_SEQ_SCAN_EN
          // Scan advances one index per PULSE cycles and finishes after LIMIT.
          S_SCAN: begin
            if (hold_last) begin
              cnt <= '0;
              if (idx == LIM_IDX) begin
                state <= S_IDLE;
                done  <= 1'b1;
                y     <= '0;
                idx   <= '0;
              end else begin
                y   <= y << 1;
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
`endif
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
            y     <= '0;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: dut uses PULSE=2, LIMIT=47; dut1 uses PULSE=1, LIMIT=63.
module tb_decoder_seq;

  typedef struct {
    logic       en;
    logic       v;
    logic       sg;
    logic [5:0] a;
  } stim_t;

  typedef struct {
    logic        rdy;
    logic [63:0] y;
    logic [5:0]  idx;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, in_valid, scan_go, in_ready, busy, done, err;
  logic [5:0]  a, idx;
  logic [63:0] y;

  logic        en1, v1, scan1, rdy1, busy1, done1, err1;
  logic [5:0]  a1, idx1;
  logic [63:0] y1;

  int checks   = 0;
  int failures = 0;

  stim_t stim_q[$];
  exp_t  sb[$];

  decoder_seq #(.AW(6), .PULSE(2), .LIMIT(47)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .scan_go(scan_go), .y(y), .idx(idx), .busy(busy), .done(done), .err(err)
  );

  decoder_seq #(.AW(6), .PULSE(1), .LIMIT(63)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .in_valid(v1), .in_ready(rdy1),
    .a(a1), .scan_go(scan1), .y(y1), .idx(idx1), .busy(busy1), .done(done1), .err(err1)
  );

  function automatic logic [63:0] onehot(int n);
    logic [63:0] v;
    v = 64'd1;
    return v << n;
  endfunction

  function automatic stim_t mks(logic e, logic v, logic sg, logic [5:0] ad);
    stim_t s;
    s.en = e; s.v = v; s.sg = sg; s.a = ad;
    return s;
  endfunction

  function automatic exp_t mke(logic r, logic [63:0] ey, logic [5:0] ei, logic b, logic d, logic ee);
    exp_t x;
    x.rdy = r; x.y = ey; x.idx = ei; x.busy = b; x.done = d; x.err = ee;
    return x;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; a = 6'd5; scan_go = 1'b0;
    en1 = 1'b1; v1 = 1'b1; a1 = 6'd3; scan1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({y, idx, busy, done, err} !== {64'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL reset cycle %0d: got y=%h idx=%0d busy=%b done=%b err=%b, expected all zero",
                 i, y, idx, busy, done, err);
      end
      checks++;
      if ({y1, idx1, busy1, done1, err1} !== {64'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL reset_dut1 cycle %0d: got y=%h idx=%0d busy=%b, expected all zero", i, y1, idx1, busy1);
      end
    end
    in_valid = 1'b0; v1 = 1'b0;
    rst = 1'b0;
  endtask

  // Drives queued stimulus into dut and checks against the scoreboard.
  task automatic run_checks_dut(string name);
    stim_t s;
    exp_t  e;
    logic  r;
    int    n = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      en = s.en; in_valid = s.v; scan_go = s.sg; a = s.a;
      #1 r = in_ready;
      tick();
      e = sb.pop_front();
      checks++;
      if ({r, y, idx, busy, done, err} !== {e.rdy, e.y, e.idx, e.busy, e.done, e.err}) begin
        failures++;
        $display("[TB] FAIL %s cycle %0d: got rdy=%b y=%h idx=%0d busy=%b done=%b err=%b, expected rdy=%b y=%h idx=%0d busy=%b done=%b err=%b",
                 name, n, r, y, idx, busy, done, err, e.rdy, e.y, e.idx, e.busy, e.done, e.err);
      end
      n++;
    end
  endtask

  task automatic test_single_pulse;
    stim_q.push_back(mks(1, 1, 0, 6'd5)); sb.push_back(mke(1, 64'h20, 6'd5, 1, 0, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0)); sb.push_back(mke(0, 64'h20, 6'd5, 1, 0, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0)); sb.push_back(mke(1, 64'd0, 6'd0, 0, 1, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0)); sb.push_back(mke(1, 64'd0, 6'd0, 0, 0, 0));
    run_checks_dut("single_pulse");
  endtask

  task automatic test_range;
    stim_q.push_back(mks(1, 1, 0, 6'd50)); sb.push_back(mke(1, 64'd0, 6'd0, 0, 0, 1));
    stim_q.push_back(mks(1, 0, 0, 6'd0));  sb.push_back(mke(1, 64'd0, 6'd0, 0, 0, 0));
    stim_q.push_back(mks(1, 1, 0, 6'd47)); sb.push_back(mke(1, onehot(47), 6'd47, 1, 0, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0));  sb.push_back(mke(0, onehot(47), 6'd47, 1, 0, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0));  sb.push_back(mke(1, 64'd0, 6'd0, 0, 1, 0));
    stim_q.push_back(mks(1, 1, 0, 6'd48)); sb.push_back(mke(1, 64'd0, 6'd0, 0, 0, 1));
    stim_q.push_back(mks(1, 0, 0, 6'd0));  sb.push_back(mke(1, 64'd0, 6'd0, 0, 0, 0));
    run_checks_dut("range");
  endtask

  task automatic test_back_to_back;
    stim_q.push_back(mks(1, 1, 0, 6'd10)); sb.push_back(mke(1, onehot(10), 6'd10, 1, 0, 0));
    stim_q.push_back(mks(1, 1, 0, 6'd11)); sb.push_back(mke(0, onehot(10), 6'd10, 1, 0, 0));
    stim_q.push_back(mks(1, 1, 0, 6'd11)); sb.push_back(mke(1, onehot(11), 6'd11, 1, 1, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0));  sb.push_back(mke(0, onehot(11), 6'd11, 1, 0, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0));  sb.push_back(mke(1, 64'd0, 6'd0, 0, 1, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0));  sb.push_back(mke(1, 64'd0, 6'd0, 0, 0, 0));
    run_checks_dut("back_to_back");
  endtask

  task automatic test_enable_abort;
    stim_q.push_back(mks(1, 1, 0, 6'd9)); sb.push_back(mke(1, onehot(9), 6'd9, 1, 0, 0));
    stim_q.push_back(mks(0, 0, 0, 6'd0)); sb.push_back(mke(0, 64'd0, 6'd0, 0, 0, 0));
    stim_q.push_back(mks(0, 1, 0, 6'd9)); sb.push_back(mke(0, 64'd0, 6'd0, 0, 0, 0));
    stim_q.push_back(mks(1, 1, 0, 6'd9)); sb.push_back(mke(1, onehot(9), 6'd9, 1, 0, 0));
    run_checks_dut("enable_abort");
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({y, idx, busy, done, err} !== {64'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL async_reset: got y=%h idx=%0d busy=%b done=%b err=%b, expected all zero",
               y, idx, busy, done, err);
    end
    #1 rst = 1'b0;
    stim_q.push_back(mks(1, 1, 0, 6'd2)); sb.push_back(mke(1, onehot(2), 6'd2, 1, 0, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0)); sb.push_back(mke(0, onehot(2), 6'd2, 1, 0, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0)); sb.push_back(mke(1, 64'd0, 6'd0, 0, 1, 0));
    run_checks_dut("post_reset_accept");
  endtask

  task automatic test_pulse1_stream;
    stim_t s;
    exp_t  e;
    logic  r;
    int    n = 0;
    stim_q.push_back(mks(1, 1, 0, 6'd0));  sb.push_back(mke(1, onehot(0), 6'd0, 1, 0, 0));
    stim_q.push_back(mks(1, 1, 0, 6'd1));  sb.push_back(mke(1, onehot(1), 6'd1, 1, 1, 0));
    stim_q.push_back(mks(1, 1, 0, 6'd63)); sb.push_back(mke(1, onehot(63), 6'd63, 1, 1, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0));  sb.push_back(mke(1, 64'd0, 6'd0, 0, 1, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0));  sb.push_back(mke(1, 64'd0, 6'd0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      en1 = s.en; v1 = s.v; scan1 = s.sg; a1 = s.a;
      #1 r = rdy1;
      tick();
      e = sb.pop_front();
      checks++;
      if ({r, y1, idx1, busy1, done1, err1} !== {e.rdy, e.y, e.idx, e.busy, e.done, e.err}) begin
        failures++;
        $display("[TB] FAIL pulse1_stream cycle %0d: got rdy=%b y=%h idx=%0d busy=%b done=%b err=%b, expected rdy=%b y=%h idx=%0d busy=%b done=%b err=%b",
                 n, r, y1, idx1, busy1, done1, err1, e.rdy, e.y, e.idx, e.busy, e.done, e.err);
      end
      n++;
    end
  endtask

`ifdef DECODER_SEQ_SCAN_EN
  task automatic test_scan;
    stim_q.push_back(mks(1, 1, 1, 6'd3)); sb.push_back(mke(0, onehot(0), 6'd0, 1, 0, 0));
    for (int k = 2; k <= 96; k++) begin
      stim_q.push_back(mks(1, (k == 20), (k == 20), 6'd3));
      sb.push_back(mke(0, onehot((k - 1) / 2), 6'((k - 1) / 2), 1, 0, 0));
    end
    stim_q.push_back(mks(1, 0, 0, 6'd0)); sb.push_back(mke(0, 64'd0, 6'd0, 0, 1, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0)); sb.push_back(mke(1, 64'd0, 6'd0, 0, 0, 0));
    run_checks_dut("scan");
  endtask
`else
  task automatic test_scan_disabled;
    stim_q.push_back(mks(1, 0, 1, 6'd0)); sb.push_back(mke(1, 64'd0, 6'd0, 0, 0, 0));
    stim_q.push_back(mks(1, 0, 1, 6'd0)); sb.push_back(mke(1, 64'd0, 6'd0, 0, 0, 0));
    stim_q.push_back(mks(1, 1, 1, 6'd7)); sb.push_back(mke(1, onehot(7), 6'd7, 1, 0, 0));
    stim_q.push_back(mks(1, 0, 1, 6'd0)); sb.push_back(mke(0, onehot(7), 6'd7, 1, 0, 0));
    stim_q.push_back(mks(1, 0, 1, 6'd0)); sb.push_back(mke(1, 64'd0, 6'd0, 0, 1, 0));
    stim_q.push_back(mks(1, 0, 0, 6'd0)); sb.push_back(mke(1, 64'd0, 6'd0, 0, 0, 0));
    run_checks_dut("scan_disabled");
  endtask
`endif

  initial begin
    test_reset();
    test_single_pulse();
    test_range();
    test_back_to_back();
    test_enable_abort();
    test_pulse1_stream();
`ifdef DECODER_SEQ_SCAN_EN
    test_scan();
`else
    test_scan_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 SHALL have parameter AW, default 6, address width; output width OW = 2**AW.
REQ-002 SHALL have parameter PULSE, default 1, cycles each one-hot output is held (legal 1..255).
REQ-003 SHALL have parameter LIMIT, default 2**AW-1, highest legal address (legal 0..2**AW-1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  block enable; low aborts activity.
REQ-007 SHALL have port in_valid  input  1  address request valid.
REQ-008 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are high on the same edge.
REQ-009 SHALL have port a  input  AW  requested address.
REQ-010 SHALL have port scan_go  input  1  start-scan request.
REQ-011 SHALL have port y  output  OW  registered one-hot output, all-zero when idle.
REQ-012 SHALL have port idx  output  AW  index currently driven on y (0 when y is zero).
REQ-013 SHALL have port busy  output  1  high in any non-IDLE state.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a pulse or scan completes normally.
REQ-015 SHALL have port err  output  1  one-cycle pulse on an accepted out-of-range address.

Function
REQ-016 SHALL implement FSM states IDLE, HOLD, SCAN; a PULSE-cycle hold counter; the idx register.
REQ-017 in_ready SHALL be high when en=1 and either the state is IDLE with scan_go=0, or the state is HOLD with the hold counter at PULSE-1.
REQ-018 On acceptance with a<=LIMIT: y=1<<a and idx=a from the next cycle, state HOLD, y held exactly PULSE cycles (latency 1).
REQ-019 On acceptance with a>LIMIT: y stays zero, err pulses the next cycle, state stays IDLE, done stays low.
REQ-020 At the end of HOLD with no new acceptance: y cleared, done pulses in the same cycle y clears, state returns to IDLE.
REQ-021 Acceptance in the final HOLD cycle SHALL load the new address with no zero gap on y (back-to-back); done SHALL still pulse for the completed pulse.
REQ-022 en=0 in any state SHALL clear y and idx on the next edge and return to IDLE, without done or err.
REQ-023 y SHALL never have more than one bit set; y is driven only from registers, with no combinational path from a to y.
REQ-024 At PULSE=1, y SHALL change every cycle under continuous back-to-back acceptance.

Reset
REQ-025 While rst=1: state IDLE, y=0, idx=0, hold counter 0, busy=0, done=0, err=0.
REQ-026 rst asserted mid-HOLD or mid-SCAN SHALL clear all outputs immediately, without done.
REQ-027 The first edge after rst deasserts SHALL be able to accept a request.

Configuration
REQ-028 Macro DECODER_SEQ_SCAN_EN SHALL gate the scan feature.
REQ-029 With DECODER_SEQ_SCAN_EN defined: scan_go=1 in IDLE with en=1 SHALL enter SCAN, taking priority over a simultaneous in_valid, which is not accepted.
REQ-030 In SCAN, idx SHALL walk 0,1,..,LIMIT, each index one-hot on y for PULSE cycles, with in_ready low throughout.
REQ-031 After index LIMIT, done SHALL pulse, y SHALL clear and the state SHALL return to IDLE; scan_go during SCAN SHALL be ignored.
REQ-032 Without DECODER_SEQ_SCAN_EN: the SCAN state SHALL be absent, scan_go SHALL be ignored, and the in_ready term ~scan_go SHALL be dropped; the port list is unchanged.

Verification (AW=6, PULSE=2, LIMIT=47 unless stated)
REQ-033 Request a=5 from IDLE -> y=64'h20, idx=5 for 2 cycles starting 1 cycle later; done on the clear cycle.
REQ-034 Request a=50 -> err pulses 1 cycle, y stays 0, busy stays 0, in_ready stays high.
REQ-035 PULSE=1, back-to-back a=0,1,63 with LIMIT=63 -> y=bit0,bit1,bit63 on consecutive cycles with no zero gap.
REQ-036 During HOLD of a=9, drop en for 1 cycle -> y=0 next cycle, no done; in the following cycle, rst mid-pulse -> immediate zero.
REQ-037 With DECODER_SEQ_SCAN_EN, scan_go and in_valid (a=3) together in IDLE -> a=3 not accepted; idx walks 0..47, 96 busy cycles, then one done pulse.
REQ-038 Without DECODER_SEQ_SCAN_EN, scan_go held high -> no activity; a=7 is still accepted normally.
